victim_cache_ctrl: RTL and testbench
====================================

// Module: victim_cache_ctrl
// PURPOSE
//  Request-side controller for the fully-associative victim cache; sits directly upstream of tag_store.
//  Accepts L1 probe (miss lookup) and insert (L1 eviction) requests and sequences tag_store commands.
//  Selects victims round-robin and issues dirty-victim writebacks to memory over a valid/ready port.
//  Handles one request at a time; exclusive policy: a probe hit invalidates the line (moves back to L1).
// PARAMETERS
//  TAG_WIDTH  4  tag bits per line; matches tag_store
//  NUM_WAYS   4  ways in victim cache; power of 2, >=2; WW = $clog2(NUM_WAYS)
// PORTS
//  clk            in   1    clock, rising edge
//  rst            in   1    asynchronous reset, active-high
//  req_valid      in   1    request present
//  req_ready      out  1    controller idle, request accepted when req_valid&&req_ready
//  req_op         in   1    0=probe, 1=insert
//  req_tag        in   TW   request tag
//  req_dirty      in   1    insert only: evicted L1 line is dirty
//  resp_valid     out  1    1-cycle completion pulse
//  resp_hit       out  1    probe: tag found; insert: tag already present (merged)
//  resp_way       out  WW   way hit (probe) / way written (insert); 0 on probe miss
//  wb_valid       out  1    dirty victim writeback request; held until wb_ready
//  wb_ready       in   1    memory accepts writeback
//  wb_tag         out  TW   tag of victim written back
//  wb_way         out  WW   way of victim written back
//  ts_write_en/ts_read_en/ts_lookup_en/ts_valid_clear/ts_dirty_set/ts_dirty_clear  out 1  tag_store commands
//  ts_tag_in      out  TW   tag to tag_store
//  ts_way_index   out  WW   way to tag_store
//  ts_hit, ts_hit_way_index, ts_valid_read, ts_dirty_read, ts_tag_read  in  (1,WW,1,1,TW)  tag_store results
// BEHAVIOUR
//  - tag_store contract: command held 1 cycle; results valid the following cycle; write_en sets valid.
//  - ts_* outputs decoded from state + latched request only (no comb path from req_*); at most one
//    ts_* command asserted per cycle, except IDLE/RESP/WB where all are 0.
//  - Reset: state=IDLE, req_ready=1, resp_valid=0, resp_hit=0, resp_way=0, wb_valid=0, wb_tag=0,
//    wb_way=0, all ts_* =0, rr_ptr=0. Reset mid-operation aborts request, drops wb_valid, no response.
//  - IDLE: req_ready=1; on handshake latch op/tag/dirty; go P_LOOK (probe) or I_LOOK (insert).
//  - P_LOOK: ts_lookup_en=1, ts_tag_in=tag -> P_EVAL.
//  - P_EVAL: capture ts_hit/ts_hit_way_index; if hit ts_valid_clear=1 at hit way -> RESP.
//  - I_LOOK: ts_lookup_en=1 -> I_EVAL.
//  - I_EVAL: hit -> victim=hit way, dup=1, go I_WRITE (no read, no writeback);
//            miss -> victim=rr_ptr, dup=0, go I_READ.
//  - I_READ: ts_read_en=1 at victim -> I_CHK.
//  - I_CHK: ts_valid_read&&ts_dirty_read -> latch wb_tag=ts_tag_read, wb_way=victim, go WB; else I_WRITE.
//  - WB: wb_valid=1, wb_tag/wb_way stable; on wb_ready -> I_WRITE (wb_valid low next cycle).
//  - I_WRITE: ts_write_en=1, tag, victim way; if !dup rr_ptr<=rr_ptr+1 (wraps NUM_WAYS-1 -> 0).
//  - I_DIRTY: req_dirty -> ts_dirty_set; !req_dirty&&!dup -> ts_dirty_clear; !req_dirty&&dup -> no-op
//    (dirty is sticky on merge). -> RESP.
//  - RESP: resp_valid=1 for exactly 1 cycle with resp_hit/resp_way -> IDLE.
//  - Latency from handshake cycle T: probe resp at T+3; insert dup T+5; insert miss, clean/invalid
//    victim T+7; dirty victim T+7+n where n = cycles wb_valid waits for wb_ready (n>=1).
//  - Back-to-back: new request accepted in cycle after RESP; req_valid in non-IDLE states ignored.
//  - rr_ptr advances only on miss-insert; probes and merges never move it.
// TESTING
//  1 reset, insert A,B,C clean -> resp_hit=0, resp_way=0,1,2; rr_ptr=3; no wb_valid
//  2 probe B -> resp at T+3 hit=1 way=1, ts_valid_clear at way1; probe B again -> hit=0 way=0
//  3 probe F (absent) -> resp_hit=0, no ts_valid_clear, rr_ptr unchanged
//  4 insert A dirty (present, way0) -> resp_hit=1 way=0, ts_dirty_set way0, no read/writeback
//  5 fill 4 ways (way0 dirty, tag A), insert D -> wb_valid with wb_tag=A wb_way=0, hold wb_ready=0
//    3 cycles then 1 -> write D way0, resp way=0, rr_ptr=1
//  6 assert rst during WB -> wb_valid=0 and req_ready=1 next edge, no resp_valid, rr_ptr=0

Source files
------------

// File: rtl/victim_cache_ctrl.sv
// Request-side controller for a fully-associative victim cache.
// Serialises L1 probe/insert requests into tag_store command sequences,
// picks victims round-robin and pushes dirty victims out over a valid/ready port.
//
// state   | meaning
// IDLE    | ready for a request
// P_LOOK  | probe: tag lookup issued
// P_EVAL  | probe: lookup result seen, invalidate line on hit
// I_LOOK  | insert: tag lookup issued
// I_EVAL  | insert: merge into hit way or pick round-robin victim
// I_READ  | insert: read victim line
// I_CHK   | insert: decide whether victim needs a writeback
// WB      | insert: writeback offered, waiting for wb_ready
// I_WRITE | insert: write tag into victim way
// I_DIRTY | insert: update dirty bit
// RESP    | one-cycle completion pulse
module victim_cache_ctrl #(
    parameter int TAG_WIDTH = 4,
    parameter int NUM_WAYS  = 4,
    localparam int WW = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [TAG_WIDTH-1:0] req_tag,
    input  logic                 req_dirty,
    output logic                 resp_valid,
    output logic                 resp_hit,
    output logic [WW-1:0]        resp_way,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [TAG_WIDTH-1:0] wb_tag,
    output logic [WW-1:0]        wb_way,
    output logic                 ts_write_en,
    output logic                 ts_read_en,
    output logic                 ts_lookup_en,
    output logic                 ts_valid_clear,
    output logic                 ts_dirty_set,
    output logic                 ts_dirty_clear,
    output logic [TAG_WIDTH-1:0] ts_tag_in,
    output logic [WW-1:0]        ts_way_index,
    input  logic                 ts_hit,
    input  logic [WW-1:0]        ts_hit_way_index,
    input  logic                 ts_valid_read,
    input  logic                 ts_dirty_read,
    input  logic [TAG_WIDTH-1:0] ts_tag_read
);

    typedef enum logic [3:0] {
        IDLE, P_LOOK, P_EVAL, I_LOOK, I_EVAL, I_READ, I_CHK, WB, I_WRITE, I_DIRTY, RESP
    } state_t;

    state_t               state;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 dirty_q;
    logic [WW-1:0]        victim_q;
    logic                 dup_q;
    logic [WW-1:0]        rr_ptr;
    logic                 hit_q;
    logic [WW-1:0]        way_q;
    logic [TAG_WIDTH-1:0] wb_tag_q;
    logic [WW-1:0]        wb_way_q;

    // Sequencer: one request at a time, latched at the IDLE handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tag_q    <= '0;
            dirty_q  <= 1'b0;
            victim_q <= '0;
            dup_q    <= 1'b0;
            rr_ptr   <= '0;
            hit_q    <= 1'b0;
            way_q    <= '0;
            wb_tag_q <= '0;
            wb_way_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        tag_q   <= req_tag;
                        dirty_q <= req_dirty;
                        state   <= req_op ? I_LOOK : P_LOOK;
                    end
                end
                P_LOOK: state <= P_EVAL;
                P_EVAL: begin
                    hit_q <= ts_hit;
                    way_q <= ts_hit ? ts_hit_way_index : '0;
                    state <= RESP;
                end
                I_LOOK: state <= I_EVAL;
                I_EVAL: begin
                    if (ts_hit) begin
                        victim_q <= ts_hit_way_index;
                        dup_q    <= 1'b1;
                        state    <= I_WRITE;
                    end else begin
                        victim_q <= rr_ptr;
                        dup_q    <= 1'b0;
                        state    <= I_READ;
                    end
                end
                I_READ: state <= I_CHK;
                I_CHK: begin
                    if (ts_valid_read && ts_dirty_read) begin
                        wb_tag_q <= ts_tag_read;
                        wb_way_q <= victim_q;
                        state    <= WB;
                    end else begin
                        state <= I_WRITE;
                    end
                end
                WB: begin
                    if (wb_ready) state <= I_WRITE;
                end
                I_WRITE: begin
                    // merges reuse an existing way, so only real allocations rotate the pointer
                    if (!dup_q) rr_ptr <= rr_ptr + WW'(1);
                    state <= I_DIRTY;
                end
                I_DIRTY: begin
                    hit_q <= dup_q;
                    way_q <= victim_q;
                    state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready      = (state == IDLE);
    assign resp_valid     = (state == RESP);
    assign resp_hit       = hit_q;
    assign resp_way       = way_q;
    assign wb_valid       = (state == WB);
    assign wb_tag         = wb_tag_q;
    assign wb_way         = wb_way_q;

    assign ts_lookup_en   = (state == P_LOOK) || (state == I_LOOK);
    assign ts_valid_clear = (state == P_EVAL) && ts_hit;
    assign ts_read_en     = (state == I_READ);
    assign ts_write_en    = (state == I_WRITE);
    // a clean merge leaves the existing dirty bit alone
    assign ts_dirty_set   = (state == I_DIRTY) && dirty_q;
    assign ts_dirty_clear = (state == I_DIRTY) && !dirty_q && !dup_q;

    // tag/way operands for whichever tag_store command is active
    always_comb begin
        ts_tag_in    = '0;
        ts_way_index = '0;
        case (state)
            P_LOOK, I_LOOK: ts_tag_in = tag_q;
            P_EVAL:         ts_way_index = ts_hit ? ts_hit_way_index : '0;
            I_READ:         ts_way_index = victim_q;
            I_WRITE: begin
                ts_tag_in    = tag_q;
                ts_way_index = victim_q;
            end
            I_DIRTY:        ts_way_index = victim_q;
            default: begin
                ts_tag_in    = '0;
                ts_way_index = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Bench for victim_cache_ctrl: behavioural tag_store, request-level cache model,
// directed vector table, randomized traffic and a reset-during-writeback sequence.
module tb_victim_cache_ctrl;
    localparam int TW = 4;
    localparam int N  = 4;
    localparam int WW = 2;

    logic          clk, rst;
    logic          req_valid, req_ready, req_op, req_dirty;
    logic [TW-1:0] req_tag;
    logic          resp_valid, resp_hit;
    logic [WW-1:0] resp_way;
    logic          wb_valid, wb_ready;
    logic [TW-1:0] wb_tag;
    logic [WW-1:0] wb_way;
    logic          ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear;
    logic [TW-1:0] ts_tag_in;
    logic [WW-1:0] ts_way_index;
    logic          ts_hit, ts_valid_read, ts_dirty_read;
    logic [WW-1:0] ts_hit_way_index;
    logic [TW-1:0] ts_tag_read;

    int checks = 0;
    int errors = 0;

    victim_cache_ctrl #(.TAG_WIDTH(TW), .NUM_WAYS(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_tag(req_tag), .req_dirty(req_dirty),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_way(wb_way),
        .ts_write_en(ts_write_en), .ts_read_en(ts_read_en), .ts_lookup_en(ts_lookup_en),
        .ts_valid_clear(ts_valid_clear), .ts_dirty_set(ts_dirty_set), .ts_dirty_clear(ts_dirty_clear),
        .ts_tag_in(ts_tag_in), .ts_way_index(ts_way_index),
        .ts_hit(ts_hit), .ts_hit_way_index(ts_hit_way_index),
        .ts_valid_read(ts_valid_read), .ts_dirty_read(ts_dirty_read), .ts_tag_read(ts_tag_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural tag_store ----------------
    logic          m_v [N];
    logic          m_d [N];
    logic [TW-1:0] m_t [N];
    logic          lk_hit;
    logic [WW-1:0] lk_way;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_v[i] <= 1'b0;
                m_d[i] <= 1'b0;
                m_t[i] <= '0;
            end
            ts_hit <= 1'b0; ts_hit_way_index <= '0;
            ts_valid_read <= 1'b0; ts_dirty_read <= 1'b0; ts_tag_read <= '0;
        end else begin
            if (ts_lookup_en) begin
                lk_hit = 1'b0;
                lk_way = '0;
                for (int i = N - 1; i >= 0; i--)
                    if (m_v[i] && m_t[i] == ts_tag_in) begin
                        lk_hit = 1'b1;
                        lk_way = WW'(i);
                    end
                ts_hit <= lk_hit;
                ts_hit_way_index <= lk_way;
            end
            if (ts_read_en) begin
                ts_valid_read <= m_v[ts_way_index];
                ts_dirty_read <= m_d[ts_way_index];
                ts_tag_read   <= m_t[ts_way_index];
            end
            if (ts_write_en) begin
                m_v[ts_way_index] <= 1'b1;
                m_t[ts_way_index] <= ts_tag_in;
            end
            if (ts_valid_clear) m_v[ts_way_index] <= 1'b0;
            if (ts_dirty_set)   m_d[ts_way_index] <= 1'b1;
            if (ts_dirty_clear) m_d[ts_way_index] <= 1'b0;
        end
    end

    // ---------------- command monitor ----------------
    int vc_cnt, rd_cnt;
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ($countones({ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear}) > 1) begin
                errors++;
                $display("FAIL ts_onehot: got %b expected at most one command at %0t",
                         {ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear}, $time);
            end
            vc_cnt += int'(ts_valid_clear);
            rd_cnt += int'(ts_read_en);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- request-level reference model ----------------
    bit            rv [N];
    bit            rd [N];
    logic [TW-1:0] rt [N];
    int            rr;

    task automatic ref_reset();
        for (int i = 0; i < N; i++) begin
            rv[i] = 0; rd[i] = 0; rt[i] = '0;
        end
        rr = 0;
    endtask

    task automatic ref_req(input bit op, input logic [TW-1:0] tag, input bit dirty, input int wbw,
                           output bit e_hit, output int e_way, output bit e_wb,
                           output logic [TW-1:0] e_wbt, output int e_wbway, output int e_lat);
        int h;
        h = -1;
        for (int i = 0; i < N; i++)
            if (h < 0 && rv[i] && rt[i] == tag) h = i;
        e_wb = 0; e_wbt = '0; e_wbway = 0;
        if (!op) begin
            e_lat = 3;
            e_hit = (h >= 0);
            e_way = (h >= 0) ? h : 0;
            if (h >= 0) rv[h] = 0;
        end else if (h >= 0) begin
            e_lat = 5; e_hit = 1; e_way = h;
            if (dirty) rd[h] = 1;
        end else begin
            e_hit = 0; e_way = rr; e_lat = 7;
            if (rv[rr] && rd[rr]) begin
                e_wb = 1; e_wbt = rt[rr]; e_wbway = rr; e_lat = 7 + wbw;
            end
            rv[rr] = 1; rt[rr] = tag; rd[rr] = dirty;
            rr = (rr + 1) % N;
        end
    endtask

    // ---------------- request driver ----------------
    // Entered and left at a falling edge; the next call may issue back-to-back.
    task automatic do_req(input bit op, input logic [TW-1:0] tag, input bit dirty, input int wbw, input bit junk,
                          output bit hit, output int way, output int lat, output bit wbs,
                          output logic [TW-1:0] wbt, output int wbway, output int nvc, output int nrd);
        bit done;
        int wbn;
        req_valid = 1'b1; req_op = op; req_tag = tag; req_dirty = dirty;
        chk("req_ready_idle", req_ready, 1);
        vc_cnt = 0; rd_cnt = 0;
        @(posedge clk); #1;
        if (junk) begin
            req_op = ~op; req_tag = ~tag; req_dirty = ~dirty;
        end else req_valid = 1'b0;
        done = 0; wbs = 0; wbn = 0; hit = 0; way = 0; lat = 0; wbt = '0; wbway = 0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (wb_valid) begin
                if (!wbs) begin
                    wbt = wb_tag; wbway = int'(wb_way);
                end else begin
                    chk("wb_tag_stable", wb_tag, wbt);
                    chk("wb_way_stable", wb_way, wbway);
                end
                wbs = 1; wbn++;
                wb_ready = (wbn >= wbw);
            end else wb_ready = 1'b0;
            if (resp_valid) begin
                done = 1; lat = k; hit = resp_hit; way = int'(resp_way);
            end
        end
        req_valid = 1'b0; wb_ready = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL resp_timeout: got no resp_valid expected one within 40 cycles");
        end
        nvc = vc_cnt; nrd = rd_cnt;
        @(negedge clk);
        chk("resp_one_cycle", resp_valid, 0);
        chk("req_ready_after", req_ready, 1);
    endtask

    task automatic compare_contents();
        for (int i = 0; i < N; i++) begin
            chk("store_valid", m_v[i], rv[i]);
            if (rv[i]) begin
                chk("store_tag", m_t[i], rt[i]);
                chk("store_dirty", m_d[i], rd[i]);
            end
        end
    endtask

    typedef struct {
        bit            op;
        logic [TW-1:0] tag;
        bit            dirty;
        int            wbw;
        bit            hit;
        int            way;
        bit            wb;
        logic [TW-1:0] wbt;
        int            wbway;
        int            lat;
    } vec_t;

    vec_t tbl [12];

    task automatic check_result(input bit op, input bit e_hit, input int e_way, input bit e_wb,
                                input logic [TW-1:0] e_wbt, input int e_wbway, input int e_lat,
                                input bit hit, input int way, input int lat, input bit wbs,
                                input logic [TW-1:0] wbt, input int wbway, input int nvc, input int nrd);
        chk("resp_hit", hit, e_hit);
        chk("resp_way", way, e_way);
        chk("latency", lat, e_lat);
        chk("wb_seen", wbs, e_wb);
        if (e_wb) begin
            chk("wb_tag", wbt, e_wbt);
            chk("wb_way", wbway, e_wbway);
        end
        chk("valid_clear_cnt", nvc, (!op && e_hit) ? 1 : 0);
        chk("read_en_cnt", nrd, (op && !e_hit) ? 1 : 0);
    endtask

    initial begin
        bit            hit, wbs, e_hit, e_wb;
        int            way, lat, wbway, nvc, nrd, e_way, e_wbway, e_lat, seen;
        logic [TW-1:0] wbt, e_wbt;

        tbl[0]  = '{1'b1, 4'hA, 1'b0, 1, 1'b0, 0, 1'b0, 4'h0, 0, 7};
        tbl[1]  = '{1'b1, 4'hB, 1'b0, 1, 1'b0, 1, 1'b0, 4'h0, 0, 7};
        tbl[2]  = '{1'b1, 4'hC, 1'b0, 1, 1'b0, 2, 1'b0, 4'h0, 0, 7};
        tbl[3]  = '{1'b0, 4'hB, 1'b0, 1, 1'b1, 1, 1'b0, 4'h0, 0, 3};
        tbl[4]  = '{1'b0, 4'hB, 1'b0, 1, 1'b0, 0, 1'b0, 4'h0, 0, 3};
        tbl[5]  = '{1'b0, 4'hF, 1'b0, 1, 1'b0, 0, 1'b0, 4'h0, 0, 3};
        tbl[6]  = '{1'b1, 4'hA, 1'b1, 1, 1'b1, 0, 1'b0, 4'h0, 0, 5};
        tbl[7]  = '{1'b1, 4'hE, 1'b0, 1, 1'b0, 3, 1'b0, 4'h0, 0, 7};
        tbl[8]  = '{1'b1, 4'hD, 1'b0, 4, 1'b0, 0, 1'b1, 4'hA, 0, 11};
        tbl[9]  = '{1'b1, 4'hB, 1'b0, 1, 1'b0, 1, 1'b0, 4'h0, 0, 7};
        tbl[10] = '{1'b1, 4'h5, 1'b1, 1, 1'b0, 2, 1'b0, 4'h0, 0, 7};
        tbl[11] = '{1'b0, 4'h5, 1'b0, 1, 1'b1, 2, 1'b0, 4'h0, 0, 3};

        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_tag = '0; req_dirty = 1'b0; wb_ready = 1'b0;
        ref_reset();
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_resp_way", resp_way, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_tag", wb_tag, 0);
        chk("rst_wb_way", wb_way, 0);
        chk("rst_ts_cmds", {ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear}, 0);
        rst = 1'b0;
        @(negedge clk);

        // directed vectors
        for (int i = 0; i < 12; i++) begin
            ref_req(tbl[i].op, tbl[i].tag, tbl[i].dirty, tbl[i].wbw, e_hit, e_way, e_wb, e_wbt, e_wbway, e_lat);
            do_req(tbl[i].op, tbl[i].tag, tbl[i].dirty, tbl[i].wbw, 1'b0, hit, way, lat, wbs, wbt, wbway, nvc, nrd);
            check_result(tbl[i].op, tbl[i].hit, tbl[i].way, tbl[i].wb, tbl[i].wbt, tbl[i].wbway, tbl[i].lat,
                         hit, way, lat, wbs, wbt, wbway, nvc, nrd);
        end
        compare_contents();

        // randomized traffic against the reference model
        for (int i = 0; i < 80; i++) begin
            bit            op, dirty, junk;
            logic [TW-1:0] tag;
            int            wbw;
            op    = 1'($urandom_range(0, 1));
            tag   = TW'($urandom_range(0, 7));
            dirty = 1'($urandom_range(0, 1));
            wbw   = $urandom_range(1, 3);
            junk  = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ref_req(op, tag, dirty, wbw, e_hit, e_way, e_wb, e_wbt, e_wbway, e_lat);
            do_req(op, tag, dirty, wbw, junk, hit, way, lat, wbs, wbt, wbway, nvc, nrd);
            check_result(op, e_hit, e_way, e_wb, e_wbt, e_wbway, e_lat, hit, way, lat, wbs, wbt, wbway, nvc, nrd);
        end
        compare_contents();

        // reset while a dirty writeback is pending
        rst = 1'b1; @(negedge clk); rst = 1'b0; ref_reset(); @(negedge clk);
        for (int t = 1; t <= 4; t++) begin
            ref_req(1'b1, TW'(t), 1'b1, 1, e_hit, e_way, e_wb, e_wbt, e_wbway, e_lat);
            do_req(1'b1, TW'(t), 1'b1, 1, 1'b0, hit, way, lat, wbs, wbt, wbway, nvc, nrd);
            check_result(1'b1, e_hit, e_way, e_wb, e_wbt, e_wbway, e_lat, hit, way, lat, wbs, wbt, wbway, nvc, nrd);
        end
        req_valid = 1'b1; req_op = 1'b1; req_tag = 4'h9; req_dirty = 1'b0;
        @(posedge clk); #1; req_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            if (wb_valid) seen = 1;
        end
        chk("abort_wb_reached", seen, 1);
        chk("abort_wb_tag", wb_tag, 1);
        rst = 1'b1; #1;
        chk("abort_wb_valid", wb_valid, 0);
        chk("abort_req_ready", req_ready, 1);
        @(negedge clk); rst = 1'b0; ref_reset();
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        chk("abort_no_resp", seen, 0);
        ref_req(1'b1, 4'h6, 1'b0, 1, e_hit, e_way, e_wb, e_wbt, e_wbway, e_lat);
        do_req(1'b1, 4'h6, 1'b0, 1, 1'b0, hit, way, lat, wbs, wbt, wbway, nvc, nrd);
        check_result(1'b1, e_hit, e_way, e_wb, e_wbt, e_wbway, e_lat, hit, way, lat, wbs, wbt, wbway, nvc, nrd);
        chk("abort_rr_way0", way, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no end of test expected finish before 500000");
        $fatal(1, "timeout");
    end
endmodule
